uart_boot_loader: RTL
=====================

# uart_boot_loader

Serial program loader in front of the single-cycle core. It receives a length-prefixed program image over a UART line and writes it word by word into the core's instruction memory through a write port. It holds the core halted until the last word is written, then releases it. On the FPGA it sits directly upstream of the processor top: it produces instruction memory contents and the processor's run/reset release.

## Interface
- `CLKS_PER_BIT`, default 868: clk cycles per UART bit (100 MHz / 115200); legal range ≥ 4.
- `ADDR_W`, default 10: instruction memory word-address width; capacity MAX_WORDS = 2**ADDR_W.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low (0 = in reset); clears all state immediately.
- `uart_rx`  in  1  asynchronous serial input, idle high, 8N1, LSB first.
- `imem_we`  out  1  one-cycle instruction memory write strobe.
- `imem_addr`  out  ADDR_W  word address of write.
- `imem_wdata`  out  32  write data word.
- `cpu_run`  out  1  0 = processor held in reset; 1 = processor released. Top-level glue maps this to the core's reset.
- `boot_done`  out  1  image fully loaded (equals `cpu_run`).
- `frame_err`  out  1  sticky: a stop bit was sampled low.
- `len_err`  out  1  sticky: header length exceeded MAX_WORDS.

## Operation
- **Reset values:** all outputs 0. The FSM enters LEN_LO, and the byte and word counters clear. Memory contents are not touched.
- **Synchronizer:** `uart_rx` passes through a 2-flop synchronizer before any use.
- **RX FSM:** IDLE → START → DATA → STOP.
  - IDLE: a synchronized falling edge moves to START.
  - START: sample at CLKS_PER_BIT/2 cycles. If the line is high, this is a false start; return to IDLE. Otherwise go to DATA.
  - DATA: sample 8 bits, each CLKS_PER_BIT cycles apart, and shift them LSB first.
  - STOP: sample once, CLKS_PER_BIT after the last data sample. If high, pulse the internal `byte_valid` for one cycle. If low, raise `frame_err`.
  - STOP → IDLE in both cases.
- **Loader FSM:** LEN_LO → LEN_HI → DATA → DONE; ERROR is terminal.
  - LEN_LO: the first byte is the low byte of word count N.
  - LEN_HI: the second byte is the high byte of N.
    - N = 0: go to DONE.
    - N > MAX_WORDS: set `len_err` and go to ERROR.
    - Otherwise go to DATA.
  - DATA: bytes are assembled little-endian; byte 0 goes to bits [7:0].
    - After the 4th byte of a word, `imem_we` = 1 for one cycle, with `imem_addr` = word index (starting at 0) and `imem_wdata` = {b3,b2,b1,b0}.
    - The word index increments after each write. After word N-1 is written, go to DONE.
  - DONE: `cpu_run` = `boot_done` = 1 and stay there until reset. Further UART bytes are received but discarded; no writes occur.
  - ERROR: any `frame_err` in LEN_LO, LEN_HI or DATA moves the FSM to ERROR. ERROR holds `cpu_run` at 0 and suppresses all writes until reset.
- **Outputs between writes:** `imem_addr` and `imem_wdata` hold their last written values; only `imem_we` qualifies them.
- **Wrap-around:** N = MAX_WORDS is legal. The last address is MAX_WORDS-1, and the address counter never wraps to overwrite word 0.

## Timing
- **Pin to byte:** `byte_valid` occurs 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the falling edge on the pin (±1 for sync phase).
- **Write strobe:** `imem_we` rises on the cycle after the `byte_valid` of each word's 4th byte.
- **Release:** `cpu_run` rises on the cycle after the final `imem_we` pulse. For N = 0, it rises on the cycle after the LEN_HI `byte_valid`.
- **Error flags:** `frame_err` and `len_err` assert on the cycle after the offending sample or byte.
- **Reset mid-operation:** asserting `reset` mid-operation forces all outputs to 0 asynchronously, including during an `imem_we` pulse or a partial word. A partial word is discarded. After release, loading restarts at LEN_LO.
- **Back-to-back bytes:** bytes with no idle gap between stop bit and next start bit are received correctly.

## Test plan
All scenarios use CLKS_PER_BIT = 16 and ADDR_W = 10.

1. Send 02 00 13 05 A0 00 93 05 10 00 AA → two `imem_we` pulses: addr 0 = 0x00A00513, addr 1 = 0x00100593. `cpu_run` = 1 exactly one cycle after the second pulse. Trailing byte AA causes no write.
2. Send 00 00 → no `imem_we`. `cpu_run` = 1 one cycle after the second byte's `byte_valid`.
3. Send 01 04 (N = 1025) → `len_err` = 1. No writes; `cpu_run` stays 0 while 4 further bytes arrive.
4. Send 01 00 then a data byte with its stop bit driven low → `frame_err` = 1, no `imem_we`, `cpu_run` = 0 until reset.
5. Pulse `uart_rx` low for 5 cycles (< 8) while in IDLE, then send 00 00 → the glitch produces no byte, and `cpu_run` = 1 after the valid header.
6. Send 01 00 EF BE, assert `reset` for 3 cycles, then send 01 00 EF BE AD DE → all outputs 0 during reset, and exactly one write: addr 0 = 0xDEADBEEF. `cpu_run` = 1 afterwards.

Source files
------------

// File: rtl/uart_boot_loader.sv
// UART program loader: receives a length-prefixed image (8N1, LSB first), writes it
// word by word into instruction memory, and releases the core once the image is complete.
`timescale 1ns/1ps
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              boot_done,
  output logic              frame_err,
  output logic              len_err,
  output logic [4:0]        o_dbg_state
);

  localparam int MAX_WORDS = 2**ADDR_W;
  localparam int CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [2:0] {
    LD_LEN_LO = 3'd0,
    LD_LEN_HI = 3'd1,
    LD_DATA   = 3'd2,
    LD_DONE   = 3'd3,
    LD_ERROR  = 3'd4
  } ld_state_t;

  // Handshake: r_byte_valid is a one-cycle pulse qualifying r_byte; there is no
  // back-pressure, the loader must consume the byte in the cycle it is valid.

  logic             r_rx_meta;
  logic             r_rx_sync;
  logic             r_rx_prev;
  logic             w_fall;

  rx_state_t        r_rx_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_byte_valid;
  logic [7:0]       r_byte;
  logic             r_stop_bad;
  logic             r_frame_err;

  ld_state_t        r_ld_state;
  logic [7:0]       r_len_lo;
  logic [ADDR_W:0]  r_len;
  logic [1:0]       r_byte_idx;
  logic [ADDR_W-1:0] r_word_idx;
  logic [23:0]      r_word;
  logic             r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]      r_imem_wdata;
  logic             r_cpu_run;
  logic             r_len_err;

  logic [15:0]      w_n;
  logic             w_last;

  // Idle-high reset value keeps the edge detector from seeing a fake start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_fall = r_rx_prev & ~r_rx_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_state   <= RX_IDLE;
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_byte       <= '0;
      r_stop_bad   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_stop_bad   <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_clk_cnt <= '0;
          if (w_fall) r_rx_state <= RX_START;
        end
        RX_START: begin
          if (r_clk_cnt == HALF_M1) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (r_clk_cnt == FULL_M1) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (r_clk_cnt == FULL_M1) begin
            r_clk_cnt <= '0;
            if (r_rx_sync) begin
              r_byte_valid <= 1'b1;
              r_byte       <= r_shift;
            end else begin
              r_stop_bad  <= 1'b1;
              r_frame_err <= 1'b1;
            end
            r_rx_state <= RX_IDLE;
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign w_n    = {r_byte, r_len_lo};
  assign w_last = ({1'b0, r_word_idx} == (r_len - (ADDR_W+1)'(1)));

  // The word index only advances on non-final writes, so N = MAX_WORDS ends at
  // MAX_WORDS-1 without wrapping back onto word 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ld_state   <= LD_LEN_LO;
      r_len_lo     <= '0;
      r_len        <= '0;
      r_byte_idx   <= '0;
      r_word_idx   <= '0;
      r_word       <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_cpu_run    <= 1'b0;
      r_len_err    <= 1'b0;
    end else begin
      r_imem_we <= 1'b0;
      case (r_ld_state)
        LD_LEN_LO: begin
          if (r_stop_bad) begin
            r_ld_state <= LD_ERROR;
          end else if (r_byte_valid) begin
            r_len_lo   <= r_byte;
            r_ld_state <= LD_LEN_HI;
          end
        end
        LD_LEN_HI: begin
          if (r_stop_bad) begin
            r_ld_state <= LD_ERROR;
          end else if (r_byte_valid) begin
            if (w_n == 16'd0) begin
              r_cpu_run  <= 1'b1;
              r_ld_state <= LD_DONE;
            end else if (32'(w_n) > 32'(MAX_WORDS)) begin
              r_len_err  <= 1'b1;
              r_ld_state <= LD_ERROR;
            end else begin
              r_len      <= (ADDR_W+1)'(w_n);
              r_byte_idx <= '0;
              r_word_idx <= '0;
              r_ld_state <= LD_DATA;
            end
          end
        end
        LD_DATA: begin
          if (r_stop_bad) begin
            r_ld_state <= LD_ERROR;
          end else if (r_byte_valid) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_imem_we    <= 1'b1;
              r_imem_addr  <= r_word_idx;
              r_imem_wdata <= {r_byte, r_word};
              if (w_last) r_ld_state <= LD_DONE;
              else        r_word_idx <= r_word_idx + ADDR_W'(1);
            end else begin
              r_word[{r_byte_idx, 3'b000} +: 8] <= r_byte;
            end
          end
        end
        LD_DONE:  r_cpu_run <= 1'b1;
        LD_ERROR: r_cpu_run <= 1'b0;
        default:  r_ld_state <= LD_ERROR;
      endcase
    end
  end

  assign imem_we     = r_imem_we;
  assign imem_addr   = r_imem_addr;
  assign imem_wdata  = r_imem_wdata;
  assign cpu_run     = r_cpu_run;
  assign boot_done   = r_cpu_run;
  assign frame_err   = r_frame_err;
  assign len_err     = r_len_err;
  assign o_dbg_state = {r_rx_state, r_ld_state};

endmodule
